// File: rtl/eespfal_dualrail_driver_pkg.sv
// Shared definitions for the EESPFAL dual-rail front end.
//   phase_e       : adiabatic phase code as seen by the power-clock generator
//   PhW           : width of the phase code
//   DrMaxW        : widest word the dual-rail helper can encode
//   dual_rail_enc : single-rail -> {complement, true} rail encoding; the future
//                   dual-rail receiver/checker uses the same helper
package eespfal_dualrail_driver_pkg;

    localparam int unsigned PhW    = 2;
    localparam int unsigned DrMaxW = 64;

    typedef enum logic [PhW-1:0] {
        PhWait    = 2'd0,
        PhEval    = 2'd1,
        PhHold    = 2'd2,
        PhRecover = 2'd3
    } phase_e;

    // Upper half is the complement rail, lower half the true rail.
    function automatic logic [2*DrMaxW-1:0] dual_rail_enc(input logic [DrMaxW-1:0] d);
        return {~d, d};
    endfunction

endpackage

// File: rtl/eespfal_dualrail_driver_if.sv
// Bundle between a word producer and the dual-rail driver.
//   in_data/in_valid/in_ready : single-rail word handshake
//   a/a_bar                   : true and complement rails to the gate row
//   dis                       : discharge enable for the gate row
//   ph                        : phase code (0 wait, 1 eval, 2 hold, 3 recover)
//   sample                    : one-cycle capture strobe, last cycle of hold
//   busy                      : high in eval, hold and recover
// master: the producer/observer side; slave: the driver.
interface eespfal_dualrail_driver_if #(
    parameter int unsigned Width = 4
) ();

    logic [Width-1:0]                            in_data;
    logic                                        in_valid;
    logic                                        in_ready;
    logic [Width-1:0]                            a;
    logic [Width-1:0]                            a_bar;
    logic                                        dis;
    logic [eespfal_dualrail_driver_pkg::PhW-1:0] ph;
    logic                                        sample;
    logic                                        busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, a, a_bar, dis, ph, sample, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, a, a_bar, dis, ph, sample, busy
    );

endinterface

// File: rtl/eespfal_dualrail_driver_phase_seq.sv
// Adiabatic phase sequencer: wait -> eval -> hold -> recover, PhaseCycles each.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : a word is buffered and may be transferred
//   ph         : registered phase code
//   load       : transfer strobe; the drive register loads on this edge
//   drive_clr  : hold->recover strobe; the drive register returns to null
//   dis        : registered discharge enable (wait phase only)
//   sample     : registered strobe on the last cycle of hold
//   busy       : registered, high in eval/hold/recover
// Wait is extended indefinitely (counter saturated, dis re-asserted) while
// nothing is buffered.
module eespfal_dualrail_driver_phase_seq
    import eespfal_dualrail_driver_pkg::*;
#(
    parameter int unsigned PhaseCycles = 4,  // 2..255
    parameter int unsigned DisCycles   = 1   // 1..PhaseCycles-1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    output phase_e ph,
    output logic   load,
    output logic   drive_clr,
    output logic   dis,
    output logic   sample,
    output logic   busy
);

    localparam int unsigned    CntW    = $clog2(PhaseCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(PhaseCycles - 1);
    localparam logic [CntW-1:0] DisEnd  = CntW'(DisCycles);

    phase_e          ph_q, ph_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            idle_d;
    logic            dis_q, dis_d;
    logic            sample_q, sample_d;
    logic            busy_q, busy_d;
    logic            last;

    assign last = (cnt_q == CntLast);

    always_comb begin
        ph_d      = ph_q;
        cnt_d     = cnt_q + 1'b1;
        idle_d    = 1'b0;
        load      = 1'b0;
        drive_clr = 1'b0;
        unique case (ph_q)
            PhWait: begin
                if (last) begin
                    if (start) begin
                        ph_d  = PhEval;
                        cnt_d = '0;
                        load  = 1'b1;
                    end else begin
                        // Idle extension: hold the counter at its last value.
                        cnt_d  = cnt_q;
                        idle_d = 1'b1;
                    end
                end
            end
            PhEval: begin
                if (last) begin
                    ph_d  = PhHold;
                    cnt_d = '0;
                end
            end
            PhHold: begin
                if (last) begin
                    ph_d      = PhRecover;
                    cnt_d     = '0;
                    drive_clr = 1'b1;
                end
            end
            PhRecover: begin
                if (last) begin
                    ph_d  = PhWait;
                    cnt_d = '0;
                end
            end
        endcase

        // Strobes are computed from the next state so they register in step with ph.
        dis_d    = (ph_d == PhWait) && ((cnt_d < DisEnd) || idle_d);
        sample_d = (ph_d == PhHold) && (cnt_d == CntLast);
        busy_d   = (ph_d != PhWait);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q     <= PhWait;
            cnt_q    <= '0;
            dis_q    <= 1'b1;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
            dis_q    <= dis_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
        end
    end

    assign ph     = ph_q;
    assign dis    = dis_q;
    assign sample = sample_q;
    assign busy   = busy_q;

endmodule

// File: rtl/eespfal_dualrail_driver.sv
// Front end for the first row of EESPFAL inverter/buffer gates.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of eespfal_dualrail_driver_if (word handshake in,
//                dual-rail drive, dis, phase code, sample and busy out)
// One-entry buffer takes a word on in_valid & in_ready; the sequencer moves it
// into the drive register at the end of wait. Rails carry the word through
// eval and hold and return to the null spacer (both rails 0) for recover/wait.
module eespfal_dualrail_driver
    import eespfal_dualrail_driver_pkg::*;
#(
    parameter int unsigned Width       = 4,  // at most DrMaxW
    parameter int unsigned PhaseCycles = 4,  // 2..255
    parameter int unsigned DisCycles   = 1   // 1..PhaseCycles-1
) (
    input logic                      clk,
    input logic                      rst_n,
    eespfal_dualrail_driver_if.slave bus
);

    logic                full_q;
    logic [Width-1:0]    buf_q;
    logic [Width-1:0]    a_q, a_d;
    logic [Width-1:0]    a_bar_q, a_bar_d;
    logic                accept;
    logic                load;
    logic                drive_clr;
    phase_e              ph;
    logic                dis;
    logic                sample;
    logic                busy;
    logic [2*DrMaxW-1:0] enc;
    logic                unused_enc;

    // Buffer is full from the accept edge until the transfer edge; a transfer
    // only happens while full, so in_ready is already low then.
    assign accept = bus.in_valid & ~full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            buf_q  <= '0;
        end else if (load) begin
            full_q <= 1'b0;
        end else if (accept) begin
            full_q <= 1'b1;
            buf_q  <= bus.in_data;
        end
    end

    eespfal_dualrail_driver_phase_seq #(
        .PhaseCycles (PhaseCycles),
        .DisCycles   (DisCycles)
    ) u_phase_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (full_q),
        .ph        (ph),
        .load      (load),
        .drive_clr (drive_clr),
        .dis       (dis),
        .sample    (sample),
        .busy      (busy)
    );

    assign enc        = dual_rail_enc(DrMaxW'(buf_q));
    // Only the low Width bits of each rail half are driven out.
    assign unused_enc = ^enc;

    always_comb begin
        a_d     = a_q;
        a_bar_d = a_bar_q;
        if (load) begin
            a_d     = enc[Width-1:0];
            a_bar_d = enc[DrMaxW +: Width];
        end else if (drive_clr) begin
            a_d     = '0;
            a_bar_d = '0;
        end
    end

    // Reset forces the null spacer on both rails without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            a_bar_q <= '0;
        end else begin
            a_q     <= a_d;
            a_bar_q <= a_bar_d;
        end
    end

    assign bus.in_ready = ~full_q;
    assign bus.a        = a_q;
    assign bus.a_bar    = a_bar_q;
    assign bus.dis      = dis;
    assign bus.ph       = ph;
    assign bus.sample   = sample;
    assign bus.busy     = busy;

endmodule

// File: doc/eespfal_dualrail_driver.md
Name: eespfal_dualrail_driver

Overview:
- Digital front end that feeds the first row of EESPFAL adiabatic gates (inverter/buffer cells) in the PRESENT80 datapath.
- Accepts single-rail words over a valid/ready handshake and buffers one word.
- Sequences the four adiabatic phases: WAIT, EVAL, HOLD, RECOVER.
- Drives complementary dual-rail inputs (A/A_BAR), the gate discharge signal (DIS), and a phase code consumed by the power-clock generator.

Parameters:
- WIDTH, 4, data bits per word; one dual-rail pair per bit.
- PHASE_CYCLES, 4, system clock cycles per adiabatic phase; legal range 2..255.
- DIS_CYCLES, 1, cycles of DIS pulse at start of WAIT; legal range 1..PHASE_CYCLES-1.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_DATA  input  WIDTH  single-rail data word.
- IN_VALID  input  1  IN_DATA valid.
- IN_READY  output  1  buffer empty; transfer when IN_VALID & IN_READY.
- A  output  WIDTH  true rail to gate inputs.
- A_BAR  output  WIDTH  complement rail to gate inputs.
- DIS  output  1  discharge enable to all gates in the row.
- PH  output  2  phase code: 0=WAIT, 1=EVAL, 2=HOLD, 3=RECOVER.
- SAMPLE  output  1  one-cycle strobe, last cycle of HOLD; downstream capture point.
- BUSY  output  1  high in EVAL, HOLD and RECOVER.

Behaviour:
- Reset (async assert, sync release): PH=0 (WAIT), phase counter=0, buffer empty, IN_READY=1, A=0, A_BAR=0, DIS=1, SAMPLE=0, BUSY=0.
- Reset asserted mid-phase: A/A_BAR drop to 0 (null spacer) immediately. DIS rises immediately.
- All outputs are registered except IN_READY, which equals the registered buffer-empty flag.
- Buffer: one entry.
  - Captures IN_DATA on a handshake.
  - IN_READY falls the next cycle.
  - Cleared on the transfer edge (see WAIT). IN_READY rises the cycle after transfer.
  - No same-cycle accept-on-transfer.
- Phase counter: counts 0..PHASE_CYCLES-1 inside each phase and resets to 0 on every phase change.
- WAIT:
  - DIS=1 for counter 0..DIS_CYCLES-1, then 0.
  - At counter==PHASE_CYCLES-1:
    - Buffer full: transfer the word to the drive register, go to EVAL.
    - Buffer empty: stay in WAIT (idle), saturate the counter, DIS=1 again until a transfer occurs.
  - A handshake during the idle extension transfers on the next edge.
- EVAL:
  - From its first cycle, A=word and A_BAR=~word; both stable for the whole phase.
  - After PHASE_CYCLES cycles, go to HOLD.
- HOLD:
  - A/A_BAR held.
  - SAMPLE=1 on the last cycle only.
  - After PHASE_CYCLES cycles, go to RECOVER.
- RECOVER:
  - From its first cycle, A=0 and A_BAR=0.
  - After PHASE_CYCLES cycles, go to WAIT with counter=0.
- Invariants:
  - A & A_BAR == 0 always.
  - A ^ A_BAR is all-ones in EVAL/HOLD and all-zeros elsewhere.
  - DIS is never 1 outside WAIT.
- Throughput: one word per 4*PHASE_CYCLES cycles when IN_VALID is held high.
- Latency: a word accepted while idle appears on A at the second edge after the handshake.
- IN_DATA changes while the buffer is full are ignored.
- Counter width: clog2(PHASE_CYCLES).

Decomposition:
- eespfal_pkg holds:
  - phase enum: WAIT, EVAL, HOLD, RECOVER with the encodings above.
  - PH_W=2.
  - a function returning the dual-rail encoding {~d, d}, shared with the future dual-rail receiver/checker.
- One sub-module, eespfal_phase_seq:
  - contains the phase FSM, phase counter, and DIS/SAMPLE/BUSY generation.
  - input: start request (buffer full).
  - outputs: PH, a load strobe, and the strobes.
- The top level holds the buffer, handshake and drive registers.

Test Plan (WIDTH=4, PHASE_CYCLES=4, DIS_CYCLES=1):
- Reset then idle, IN_VALID=0 for 20 cycles -> PH=0, DIS=1 continuously after the initial pulse, A=A_BAR=0, IN_READY=1, BUSY=0.
- Single word 4'hA while idle -> A=4'hA and A_BAR=4'h5 for exactly 8 cycles (EVAL+HOLD). SAMPLE high on the 8th. RECOVER 4 cycles with A=A_BAR=0. Then WAIT with DIS high for 1 cycle.
- IN_VALID held high with words 1,2,3 -> one word per 16 cycles. IN_READY low while the buffer holds the next word. Output sequence 1,2,3 with no loss or duplication.
- Word offered during HOLD of the previous word -> buffered. Transfer occurs at WAIT counter==3. EVAL starts exactly 4 cycles after RECOVER ends.
- RST_N pulsed low mid-HOLD with A=4'hF -> A=A_BAR=0 and DIS=1 without waiting for CLK. After release: PH=0, buffer empty.
- Random traffic, 1000 words, with assertions -> A & A_BAR==0 always. DIS never 1 outside WAIT. Data order preserved.
